hsst_pll_rst_fsm: RTL and testbench

- Per-PLL reset sequencer for the HSST, one stage upstream of the TX lane reset FSM.
- Sequences PLL power-down and reset release, then waits for a debounced lock with timeout and bounded retries.
- Its `o_pll_done` output drives the TX lane FSM's PLL-lock input and reset release.
- Re-runs the PLL reset on loss of lock or on a software request.

---
 rtl/hsst_pll_rst_fsm_pkg.sv | 38 +++
 rtl/hsst_sync_2ff.sv | 25 ++
 rtl/hsst_pll_rst_fsm.sv | 197 +++++++++++++++++++
 tb/tb_hsst_pll_rst_fsm.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hsst_pll_rst_fsm_pkg.sv
// Shared definitions for the HSST PLL reset sequencer: state encodings,
// counter widths and the phase count constants.
package hsst_pll_rst_fsm_pkg;

   localparam int CNTR0_W = 14;
   localparam int CNTR1_W = 17;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PLL_PD    = 3'd1,
      PLL_RST   = 3'd2,
      WAIT_LOCK = 3'd3,
      DEBOUNCE  = 3'd4,
      DONE      = 3'd5,
      FAIL      = 3'd6
   } pll_state_e;

   // Power-down hold time in clock cycles (2x margin included).
   function automatic int pd_cnt(input int freq, input int sim);
      return (sim != 0) ? 2 * freq : 80 * freq;
   endfunction

   // Total power-down plus reset hold time in clock cycles.
   function automatic int rst_cnt(input int freq, input int sim);
      return (sim != 0) ? 4 * freq : 82 * freq;
   endfunction

   // Lock debounce time in clock cycles.
   function automatic int stable_cnt(input int freq, input int sim);
      return (sim != 0) ? freq : 20 * freq;
   endfunction

   // Lock acquisition timeout in clock cycles.
   function automatic int timeout_cnt(input int freq, input int sim);
      return (sim != 0) ? 20 * freq : 1000 * freq;
   endfunction

endpackage

// File: rtl/hsst_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module hsst_sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops give the first stage a full cycle to settle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= i_d;
         sync_q <= meta_q;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/hsst_pll_rst_fsm.sv
// Per-PLL reset sequencer: power-down, reset release, debounced lock wait
// with timeout and bounded retries, restart on lock loss or software request.
module hsst_pll_rst_fsm
   import hsst_pll_rst_fsm_pkg::*;
#(
   parameter int FREE_CLOCK_FREQ = 100,
   parameter int SIM_SPEEDUP     = 0,
   parameter int MAX_RETRY       = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_pll_lock,
   input  logic       i_pll_rst_req,
   output logic       P_PLL_PD,
   output logic       P_PLL_RST,
   output logic       o_pll_done,
   output logic       o_lock_lost,
   output logic       o_pll_lock_err,
   output logic [2:0] o_retry_cnt
);

   localparam logic [CNTR0_W-1:0] PD_CNT     = CNTR0_W'(pd_cnt(FREE_CLOCK_FREQ, SIM_SPEEDUP));
   localparam logic [CNTR0_W-1:0] RST_PHASE  = CNTR0_W'(rst_cnt(FREE_CLOCK_FREQ, SIM_SPEEDUP)
                                                       - pd_cnt(FREE_CLOCK_FREQ, SIM_SPEEDUP));
   localparam logic [CNTR0_W-1:0] STABLE_CNT = CNTR0_W'(stable_cnt(FREE_CLOCK_FREQ, SIM_SPEEDUP));
   localparam logic [CNTR1_W-1:0] TIMEOUT_CNT = CNTR1_W'(timeout_cnt(FREE_CLOCK_FREQ, SIM_SPEEDUP));
   localparam logic [2:0]         MAX_RETRY_V = 3'(MAX_RETRY);

   pll_state_e         state_q, state_d;
   logic [CNTR0_W-1:0] cntr0_q, cntr0_d;
   logic [CNTR1_W-1:0] cntr1_q, cntr1_d;
   logic [2:0]         retry_q, retry_d;
   logic               pd_q, pd_d;
   logic               pll_rst_q, pll_rst_d;
   logic               done_q, done_d;
   logic               lost_q, lost_d;
   logic               err_q, err_d;
   logic               req_q, req_d;
   logic               lock_s;
   logic               timeout;
   logic               req_rise;

   hsst_sync_2ff u_lock_sync (
      .clk (clk),
      .rst (rst),
      .i_d (i_pll_lock),
      .o_q (lock_s)
   );

   assign timeout  = (cntr1_q == TIMEOUT_CNT);
   assign req_rise = i_pll_rst_req & ~req_q;

   // Next-state and registered-output logic; a software restart overrides everything.
   always_comb begin
      state_d   = state_q;
      cntr0_d   = cntr0_q;
      cntr1_d   = cntr1_q;
      retry_d   = retry_q;
      pd_d      = pd_q;
      pll_rst_d = pll_rst_q;
      done_d    = done_q;
      lost_d    = 1'b0;
      err_d     = err_q;
      req_d     = i_pll_rst_req;

      if (req_rise && (state_q != IDLE)) begin
         state_d   = PLL_PD;
         cntr0_d   = '0;
         cntr1_d   = '0;
         retry_d   = '0;
         pd_d      = 1'b1;
         pll_rst_d = 1'b1;
         done_d    = 1'b0;
         err_d     = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d   = PLL_PD;
               cntr0_d   = '0;
               cntr1_d   = '0;
               retry_d   = '0;
               pd_d      = 1'b1;
               pll_rst_d = 1'b1;
               done_d    = 1'b0;
               err_d     = 1'b0;
            end
            PLL_PD: begin
               if (cntr0_q == PD_CNT) begin
                  pd_d    = 1'b0;
                  cntr0_d = '0;
                  state_d = PLL_RST;
               end else begin
                  cntr0_d = cntr0_q + CNTR0_W'(1);
               end
            end
            PLL_RST: begin
               if (cntr0_q == RST_PHASE) begin
                  pll_rst_d = 1'b0;
                  cntr0_d   = '0;
                  cntr1_d   = '0;
                  state_d   = WAIT_LOCK;
               end else begin
                  cntr0_d = cntr0_q + CNTR0_W'(1);
               end
            end
            WAIT_LOCK, DEBOUNCE: begin
               if (timeout) begin
                  if (retry_q == MAX_RETRY_V) begin
                     state_d   = FAIL;
                     pd_d      = 1'b1;
                     pll_rst_d = 1'b1;
                     err_d     = 1'b1;
                     done_d    = 1'b0;
                  end else begin
                     retry_d   = retry_q + 3'd1;
                     pll_rst_d = 1'b1;
                     cntr0_d   = '0;
                     cntr1_d   = '0;
                     state_d   = PLL_RST;
                  end
               end else begin
                  cntr1_d = cntr1_q + CNTR1_W'(1);
                  if (state_q == WAIT_LOCK) begin
                     if (lock_s) begin
                        cntr0_d = '0;
                        state_d = DEBOUNCE;
                     end
                  end else if (!lock_s) begin
                     state_d = WAIT_LOCK;
                  end else if (cntr0_q == STABLE_CNT) begin
                     done_d  = 1'b1;
                     retry_d = '0;
                     state_d = DONE;
                  end else begin
                     cntr0_d = cntr0_q + CNTR0_W'(1);
                  end
               end
            end
            DONE: begin
               if (!lock_s) begin
                  done_d    = 1'b0;
                  lost_d    = 1'b1;
                  pll_rst_d = 1'b1;
                  cntr0_d   = '0;
                  cntr1_d   = '0;
                  retry_d   = '0;
                  state_d   = PLL_RST;
               end
            end
            FAIL: begin
               pd_d      = 1'b1;
               pll_rst_d = 1'b1;
               err_d     = 1'b1;
               done_d    = 1'b0;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, counters and outputs all register here so every output is glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cntr0_q   <= '0;
         cntr1_q   <= '0;
         retry_q   <= '0;
         pd_q      <= 1'b1;
         pll_rst_q <= 1'b1;
         done_q    <= 1'b0;
         lost_q    <= 1'b0;
         err_q     <= 1'b0;
         req_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cntr0_q   <= cntr0_d;
         cntr1_q   <= cntr1_d;
         retry_q   <= retry_d;
         pd_q      <= pd_d;
         pll_rst_q <= pll_rst_d;
         done_q    <= done_d;
         lost_q    <= lost_d;
         err_q     <= err_d;
         req_q     <= req_d;
      end
   end

   assign P_PLL_PD       = pd_q;
   assign P_PLL_RST      = pll_rst_q;
   assign o_pll_done     = done_q;
   assign o_lock_lost    = lost_q;
   assign o_pll_lock_err = err_q;
   assign o_retry_cnt    = retry_q;

endmodule

// File: tb/tb_hsst_pll_rst_fsm.sv
// Scoreboard bench for hsst_pll_rst_fsm with shortened counts (10 MHz, SIM_SPEEDUP).
// The stimulus pushes every expected output change with its clock cycle; a
// monitor pops and compares each time the output vector actually changes.
module tb_hsst_pll_rst_fsm;

   localparam int FREQ = 10;
   localparam int P    = 20;    // PD_CNT
   localparam int R    = 40;    // RST_CNT
   localparam int S    = 10;    // STABLE_CNT
   localparam int T    = 200;   // TIMEOUT_CNT
   localparam int RP   = R - P;
   localparam logic [7:0] RESET_VEC = 8'b1100_0000;

   typedef struct {
      string      name;
      int         cyc;
      logic [7:0] vec;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       lockIn = 1'b0;
   logic       rstReq = 1'b0;
   logic       pllPd, pllRst, pllDone, lockLost, lockErr;
   logic [2:0] retryCnt;
   logic [7:0] outVec;
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   exp_t       scoreQ[$];

   hsst_pll_rst_fsm #(
      .FREE_CLOCK_FREQ (FREQ),
      .SIM_SPEEDUP     (1),
      .MAX_RETRY       (3)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_pll_lock     (lockIn),
      .i_pll_rst_req  (rstReq),
      .P_PLL_PD       (pllPd),
      .P_PLL_RST      (pllRst),
      .o_pll_done     (pllDone),
      .o_lock_lost    (lockLost),
      .o_pll_lock_err (lockErr),
      .o_retry_cnt    (retryCnt)
   );

   assign outVec = {pllPd, pllRst, pllDone, lockLost, lockErr, retryCnt};

   // Free-running clock and an edge counter used to timestamp every change.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] mkVec(input logic pd, input logic rs, input logic dn,
                                        input logic ll, input logic er, input logic [2:0] rc);
      return {pd, rs, dn, ll, er, rc};
   endfunction

   task automatic expectEvent(input string name, input int atCyc, input logic [7:0] v);
      exp_t e;
      e.name = name;
      e.cyc  = atCyc;
      e.vec  = v;
      scoreQ.push_back(e);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic lockV, input logic reqV);
      lockIn = lockV;
      rstReq = reqV;
   endtask

   task automatic checkOutput(input string name, input int expCyc, input logic [7:0] expVec,
                              input int actCyc, input logic [7:0] actVec);
      checks++;
      if (actCyc != expCyc || actVec !== expVec) begin
         failures++;
         $display("[TB] FAIL %s: got {pd,rst,done,lost,err,retry}=%b at cycle %0d, required %b at cycle %0d",
                  name, actVec, actCyc, expVec, expCyc);
      end
   endtask

   // Monitor: each settled change of the outputs consumes one scoreboard entry.
   initial begin
      exp_t       e;
      logic [7:0] lastVec;
      #3;
      if (scoreQ.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL reset_state: scoreboard empty at start");
      end else begin
         e = scoreQ.pop_front();
         checkOutput(e.name, e.cyc, e.vec, cyc, outVec);
      end
      lastVec = outVec;
      forever begin
         @(outVec);
         #1;
         if (outVec !== lastVec) begin
            lastVec = outVec;
            if (scoreQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_change: got %b at cycle %0d, required no change",
                        outVec, cyc);
            end else begin
               e = scoreQ.pop_front();
               checkOutput(e.name, e.cyc, e.vec, cyc, outVec);
            end
         end
      end
   end

   // Directed scenarios with hand-computed cycle offsets.
   initial begin
      int c0, lk, d, d2, x, f, l2, c1, w;
      exp_t e;

      // Reset state, applied asynchronously before the first clock edge.
      expectEvent("reset_state", 0, RESET_VEC);
      #1 rst = 1'b1;
      waitCycles(3);

      // Clean bring-up.
      rst = 1'b0;
      c0  = cyc;
      expectEvent("bringup_pd_fall", c0 + P + 2, mkVec(0, 1, 0, 0, 0, 3'd0));
      expectEvent("bringup_rst_fall", c0 + R + 3, mkVec(0, 0, 0, 0, 0, 3'd0));
      waitCycles(R + 3 + 50);
      lk = cyc;
      applyStimulus(1'b1, 1'b0);
      expectEvent("bringup_done", lk + S + 4, mkVec(0, 0, 1, 0, 0, 3'd0));
      waitCycles(S + 4 + 5);

      // One-cycle lock drop while in DONE, then relock.
      d = cyc;
      expectEvent("lost_pulse", d + 3, mkVec(0, 1, 0, 1, 0, 3'd0));
      expectEvent("lost_pulse_end", d + 4, mkVec(0, 1, 0, 0, 0, 3'd0));
      expectEvent("relock_rst_fall", d + 3 + RP + 1, mkVec(0, 0, 0, 0, 0, 3'd0));
      expectEvent("relock_done", d + 3 + RP + 1 + S + 2, mkVec(0, 0, 1, 0, 0, 3'd0));
      applyStimulus(1'b0, 1'b0);
      waitCycles(1);
      applyStimulus(1'b1, 1'b0);
      waitCycles(40);

      // Chattering lock: three retries, then FAIL.
      d2 = cyc;
      expectEvent("chatter_lost", d2 + 3, mkVec(0, 1, 0, 1, 0, 3'd0));
      expectEvent("chatter_lost_end", d2 + 4, mkVec(0, 1, 0, 0, 0, 3'd0));
      x = d2 + 3 + RP + 1;
      expectEvent("chatter_rst_fall0", x, mkVec(0, 0, 0, 0, 0, 3'd0));
      for (int k = 1; k <= 3; k++) begin
         x += T + 1;
         expectEvent($sformatf("timeout_retry%0d", k), x, mkVec(0, 1, 0, 0, 0, 3'(k)));
         x += RP + 1;
         expectEvent($sformatf("retry%0d_rst_fall", k), x, mkVec(0, 0, 0, 0, 0, 3'(k)));
      end
      x += T + 1;
      expectEvent("enter_fail", x, mkVec(1, 1, 0, 0, 1, 3'd3));
      applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 180; i++) begin
         waitCycles(5);
         applyStimulus(~lockIn, 1'b0);
      end
      applyStimulus(1'b0, 1'b0);
      waitCycles(5);

      // Software restart from FAIL.
      f = cyc;
      expectEvent("restart_err_clear", f + 1, mkVec(1, 1, 0, 0, 0, 3'd0));
      expectEvent("restart_pd_fall", f + 1 + P + 1, mkVec(0, 1, 0, 0, 0, 3'd0));
      expectEvent("restart_rst_fall", f + R + 3, mkVec(0, 0, 0, 0, 0, 3'd0));
      applyStimulus(1'b0, 1'b1);
      waitCycles(3);
      applyStimulus(1'b0, 1'b0);
      waitCycles(47);

      // Asynchronous reset in the middle of DEBOUNCE.
      l2 = cyc;
      applyStimulus(1'b1, 1'b0);
      waitCycles(7);
      expectEvent("async_reset_mid_debounce", cyc, RESET_VEC);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0);
      waitCycles(2);

      // Lock reaching lock_s on the exact timeout cycle: retry wins.
      rst = 1'b0;
      c1  = cyc;
      w   = c1 + R + 3;
      expectEvent("edge_pd_fall", c1 + P + 2, mkVec(0, 1, 0, 0, 0, 3'd0));
      expectEvent("edge_rst_fall", w, mkVec(0, 0, 0, 0, 0, 3'd0));
      expectEvent("edge_timeout_wins", w + T + 1, mkVec(0, 1, 0, 0, 0, 3'd1));
      expectEvent("edge_retry_rst_fall", w + T + 1 + RP + 1, mkVec(0, 0, 0, 0, 0, 3'd1));
      expectEvent("edge_done_retry_clear", w + T + 1 + RP + 1 + S + 2, mkVec(0, 0, 1, 0, 0, 3'd0));
      waitCycles(R + 3 + T - 2 - l2 + l2);
      applyStimulus(1'b1, 1'b0);
      waitCycles(60);

      // Anything still queued never appeared on the outputs.
      while (scoreQ.size() > 0) begin
         e = scoreQ.pop_front();
         checks++;
         failures++;
         $display("[TB] FAIL %s: got no output change by cycle %0d, required %b at cycle %0d",
                  e.name, cyc, e.vec, e.cyc);
      end

      $display("%0d/%0d checks passed", checks - failures, checks);
      $finish;
   end

endmodule
